// File: rtl/aes_block_packer.sv
// Packs a stream of 32-bit message words into 128-bit AES input blocks.
// The final block is PKCS#7 padded (PAD_EN=1) or zero padded (PAD_EN=0).
module aes_block_packer #(
    parameter int PAD_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:31]  in_word,
    input  logic [2:0]   in_bytes,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [0:127] block_out,
    output logic         valid_out,
    output logic         last_out
);

    typedef enum logic {ACCUM, PAD} state_t;

    state_t       state;
    logic [1:0]   idx;
    logic [0:127] data_buf;
    logic [2:0]   n_bytes;
    logic [4:0]   data_cnt;
    logic         block_full;
    logic [0:127] last_block;

    // Out-of-range byte counts on a last word mean a full word.
    function automatic logic [2:0] eff_bytes(input logic [2:0] bytes);
        return (bytes >= 3'd1 && bytes <= 3'd4) ? bytes : 3'd4;
    endfunction

    function automatic logic [0:127] pack_last(
        input logic [0:127] partial,
        input logic [0:31]  word,
        input logic [1:0]   widx,
        input logic [2:0]   nb
    );
        logic [0:127] blk;
        int base;
        int cnt;
        base = 4 * int'(widx);
        cnt  = base + int'(nb);
        blk  = '0;
        for (int j = 0; j < 16; j++) begin
            if (j < base)
                blk[8*j +: 8] = partial[8*j +: 8];
            else if (j < cnt)
                blk[8*j +: 8] = word[8*(j-base) +: 8];
            else if (PAD_EN != 0)
                blk[8*j +: 8] = 8'(16 - cnt);
        end
        return blk;
    endfunction

    assign in_ready   = (state == ACCUM) && rst_n;
    assign n_bytes    = eff_bytes(in_bytes);
    assign data_cnt   = {1'b0, idx, 2'b00} + {2'b00, n_bytes};
    assign block_full = (data_cnt == 5'd16);
    assign last_block = pack_last(data_buf, in_word, idx, n_bytes);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            idx       <= 2'd0;
            data_buf  <= '0;
            block_out <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (state == PAD) begin
                // Extra block after a message that filled its last block exactly.
                block_out <= {16{8'h10}};
                valid_out <= 1'b1;
                last_out  <= 1'b1;
                state     <= ACCUM;
            end else if (in_valid) begin
                if (!in_last) begin
                    data_buf[32*idx +: 32] <= in_word;
                    idx                    <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        block_out <= {data_buf[0:95], in_word};
                        valid_out <= 1'b1;
                        last_out  <= 1'b0;
                    end
                end else begin
                    block_out <= last_block;
                    valid_out <= 1'b1;
                    idx       <= 2'd0;
                    if (block_full && PAD_EN != 0) begin
                        last_out <= 1'b0;
                        state    <= PAD;
                    end else begin
                        last_out <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: one PKCS#7 instance and one zero-pad
// instance, compared against a byte-level software padding model.
module tb_aes_block_packer;

    typedef struct {
        logic [0:127] blk;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [0:31]  in_word = '0;
    logic [2:0]   in_bytes = 3'd0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         sel = 1'b0;   // 0 routes stimulus to the PKCS#7 instance, 1 to zero-pad

    logic         rdy1, v1, l1, rdy0, v0, l0, rdy;
    logic [0:127] blk1, blk0;

    exp_t q1[$];
    exp_t q0[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    aes_block_packer #(.PAD_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_bytes(in_bytes),
        .in_valid(in_valid && !sel), .in_last(in_last), .in_ready(rdy1),
        .block_out(blk1), .valid_out(v1), .last_out(l1)
    );

    aes_block_packer #(.PAD_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_bytes(in_bytes),
        .in_valid(in_valid && sel), .in_last(in_last), .in_ready(rdy0),
        .block_out(blk0), .valid_out(v0), .last_out(l0)
    );

    assign rdy = sel ? rdy0 : rdy1;

    // Scoreboard: every output pulse must match the next expected block.
    always @(negedge clk) begin
        exp_t e;
        if (v1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                $display("FAIL pad_unexpected_pulse: got block %h last %b, expected no pulse", blk1, l1);
            end else begin
                e = q1.pop_front();
                if (blk1 !== e.blk || l1 !== e.last)
                    $display("FAIL pad_block: got %h last %b, expected %h last %b", blk1, l1, e.blk, e.last);
                else
                    passed++;
            end
        end
        if (v0 === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                $display("FAIL zero_unexpected_pulse: got block %h last %b, expected no pulse", blk0, l0);
            end else begin
                e = q0.pop_front();
                if (blk0 !== e.blk || l0 !== e.last)
                    $display("FAIL zero_block: got %h last %b, expected %h last %b", blk0, l0, e.blk, e.last);
                else
                    passed++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic model_push(input logic [7:0] msg[$], input bit nopad);
        logic [7:0] b[$];
        int pad;
        int nblk;
        exp_t e;
        b = msg;
        if (!nopad) begin
            pad = 16 - (msg.size() % 16);
            repeat (pad) b.push_back(8'(pad));
        end else begin
            while (b.size() % 16 != 0) b.push_back(8'h00);
        end
        nblk = b.size() / 16;
        for (int k = 0; k < nblk; k++) begin
            for (int j = 0; j < 16; j++) e.blk[8*j +: 8] = b[16*k + j];
            e.last = (k == nblk - 1);
            if (nopad) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send_word(input logic [0:31] w, input logic lst, input logic [2:0] nb, input bit stall);
        int guard;
        bit ok;
        if (stall) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        in_word  = w;
        in_last  = lst;
        in_bytes = nb;
        in_valid = 1'b1;
        guard = 0;
        ok = 1'b0;
        while (!ok && guard < 20) begin
            @(negedge clk);
            ok = rdy;
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (!ok) $display("FAIL ready_timeout: got in_ready 0 for %0d cycles, expected 1", guard);
        else passed++;
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit nopad, input bit stall);
        int len, nw, n;
        logic [0:31] w;
        logic [2:0] nb;
        bit lst;
        sel = nopad;
        model_push(msg, nopad);
        len = msg.size();
        nw = (len + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            n = (len - 4*i >= 4) ? 4 : len - 4*i;
            w = $urandom();
            for (int j = 0; j < n; j++) w[8*j +: 8] = msg[4*i + j];
            lst = (i == nw - 1);
            nb = 3'(n);
            if (lst && n == 4 && $urandom_range(0, 1) == 1)
                nb = 3'($urandom_range(5, 8));
            else if (!lst)
                nb = 3'($urandom_range(0, 7));
            send_word(w, lst, nb, stall);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q1.size() != 0 || q0.size() != 0) && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            $display("FAIL drain: got %0d/%0d blocks outstanding, expected 0", q1.size(), q0.size());
            q1.delete();
            q0.delete();
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rdy1, v1, l1, blk1, rdy0, v0, l0, blk0} !== '0)
            $display("FAIL reset_values: got rdy %b%b valid %b%b last %b%b, expected all 0", rdy1, rdy0, v1, v0, l1, l0);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rdy1 !== 1'b1 || rdy0 !== 1'b1)
            $display("FAIL ready_after_reset: got %b%b, expected 11", rdy1, rdy0);
        else passed++;
    endtask

    task automatic test_full_block();
        logic [0:127] exp_blk;
        exp_blk = 128'h00112233445566778899aabbccddeeff;
        sel = 1'b0;
        q1.push_back('{blk: exp_blk, last: 1'b0});
        send_word(32'h00112233, 1'b0, 3'd0, 1'b0);
        send_word(32'h44556677, 1'b0, 3'd0, 1'b0);
        send_word(32'h8899aabb, 1'b0, 3'd0, 1'b0);
        checks++;
        if (v1 !== 1'b0) $display("FAIL full_early_valid: got %b, expected 0", v1);
        else passed++;
        send_word(32'hccddeeff, 1'b0, 3'd0, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (v1 !== 1'b1 || l1 !== 1'b0 || blk1 !== exp_blk)
            $display("FAIL full_latency: got valid %b last %b %h, expected 1 0 %h", v1, l1, blk1, exp_blk);
        else passed++;
        drain();
    endtask

    task automatic test_async_reset();
        sel = 1'b0;
        send_word(32'hdeadbeef, 1'b0, 3'd0, 1'b0);
        send_word(32'hcafef00d, 1'b0, 3'd0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (blk1 !== '0 || v1 !== 1'b0 || l1 !== 1'b0 || rdy1 !== 1'b0)
            $display("FAIL async_reset: got block %h valid %b last %b rdy %b, expected all 0", blk1, v1, l1, rdy1);
        else passed++;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rdy1 !== 1'b1) $display("FAIL async_reset_release: got rdy %b, expected 1", rdy1);
        else passed++;
    endtask

    task automatic test_short();
        logic [0:127] exp_blk;
        exp_blk = {40'h0102030405, {11{8'h0b}}};
        sel = 1'b0;
        q1.push_back('{blk: exp_blk, last: 1'b1});
        send_word(32'h01020304, 1'b0, 3'd0, 1'b0);
        send_word(32'h05000000, 1'b1, 3'd1, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (v1 !== 1'b1 || l1 !== 1'b1 || blk1 !== exp_blk)
            $display("FAIL short_msg: got valid %b last %b %h, expected 1 1 %h", v1, l1, blk1, exp_blk);
        else passed++;
        drain();
    endtask

    task automatic test_16byte();
        sel = 1'b0;
        q1.push_back('{blk: 128'h00112233445566778899aabbccddeeff, last: 1'b0});
        q1.push_back('{blk: {16{8'h10}}, last: 1'b1});
        send_word(32'h00112233, 1'b0, 3'd0, 1'b0);
        send_word(32'h44556677, 1'b0, 3'd0, 1'b0);
        send_word(32'h8899aabb, 1'b0, 3'd0, 1'b0);
        send_word(32'hccddeeff, 1'b1, 3'd4, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (rdy1 !== 1'b0 || v1 !== 1'b1 || l1 !== 1'b0)
            $display("FAIL pad_data_block: got rdy %b valid %b last %b, expected 0 1 0", rdy1, v1, l1);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (rdy1 !== 1'b1 || v1 !== 1'b1 || l1 !== 1'b1)
            $display("FAIL pad_extra_block: got rdy %b valid %b last %b, expected 1 1 1", rdy1, v1, l1);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (v1 !== 1'b0) $display("FAIL pad_pulse_end: got valid %b, expected 0", v1);
        else passed++;
        drain();
    endtask

    task automatic test_nopad();
        sel = 1'b1;
        q0.push_back('{blk: {40'h0102030405, 88'h0}, last: 1'b1});
        send_word(32'h01020304, 1'b0, 3'd0, 1'b0);
        send_word(32'h05000000, 1'b1, 3'd1, 1'b0);
        in_valid = 1'b0;
        drain();
        q0.push_back('{blk: 128'h00112233445566778899aabbccddeeff, last: 1'b1});
        send_word(32'h00112233, 1'b0, 3'd0, 1'b0);
        send_word(32'h44556677, 1'b0, 3'd0, 1'b0);
        send_word(32'h8899aabb, 1'b0, 3'd0, 1'b0);
        send_word(32'hccddeeff, 1'b1, 3'd4, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (rdy0 !== 1'b1 || v0 !== 1'b1 || l0 !== 1'b1)
            $display("FAIL nopad_full: got rdy %b valid %b last %b, expected 1 1 1", rdy0, v0, l0);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (v0 !== 1'b0) $display("FAIL nopad_no_extra: got valid %b, expected 0", v0);
        else passed++;
        drain();
        sel = 1'b0;
    endtask

    task automatic test_stall_reset();
        logic [7:0] msg[$];
        sel = 1'b0;
        send_word($urandom(), 1'b0, 3'd0, 1'b1);
        send_word($urandom(), 1'b0, 3'd0, 1'b1);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        msg.delete();
        for (int i = 0; i < 23; i++) msg.push_back(8'($urandom()));
        send_msg(msg, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg[$];
        int lens[6] = '{16, 3, 32, 4, 17, 1};
        for (int nopad = 0; nopad < 2; nopad++) begin
            for (int m = 0; m < 6; m++) begin
                msg.delete();
                for (int i = 0; i < lens[m]; i++) msg.push_back(8'($urandom()));
                send_msg(msg, nopad[0], 1'b0);
            end
            drain();
        end
    endtask

    task automatic test_random_msgs();
        logic [7:0] msg[$];
        for (int m = 0; m < 12; m++) begin
            msg.delete();
            repeat ($urandom_range(1, 40)) msg.push_back(8'($urandom()));
            send_msg(msg, m[0], $urandom_range(0, 1) == 1);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_async_reset();
        test_short();
        test_16byte();
        test_nopad();
        test_stall_reset();
        test_back_to_back();
        test_random_msgs();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
